// File: rtl/spi_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter_if
//   Requester-side bus of the SPI master arbiter. It carries every
//   requester's frame request and the shared response/status lines.
//
//   req_valid  [NUM_REQ]     per-requester frame request, held until req_ready
//   req_mode   [2*NUM_REQ]   SPI mode per requester (1 or 3 are legal)
//   req_wdata  [16*NUM_REQ]  frame to transmit per requester
//   req_ready  [NUM_REQ]     one-hot accept pulse
//   rsp_valid  [NUM_REQ]     one-hot end-of-frame pulse
//   rsp_rdata  [16]          received frame, valid with rsp_valid
//   rsp_err    [1]           timeout / illegal-mode abort, valid with rsp_valid
//   busy       [1]           arbiter is not idle
//   gnt_id     [ID_W]        current owner, valid while busy
//
//   Modports:
//     master : requester side (drives requests, observes responses)
//     slave  : arbiter side
// ---------------------------------------------------------------------------
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [2*NUM_REQ-1:0]  req_mode;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic [ID_W-1:0]       gnt_id;

  modport master (
    output req_valid, req_mode, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, gnt_id
  );

  modport slave (
    input  req_valid, req_mode, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, gnt_id
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter
//   Shares one 16-bit spi_master between NUM_REQ requesters, one frame per
//   grant. Sequences spi_en / spi_mode / spi_sdata towards the master and
//   returns spi_rdata to the owning requester.
//
//   Ports:
//     sys_clk, sys_rst_n   clock, asynchronous active-low reset
//     req_if (slave)       requester bus (see spi_master_arbiter_if)
//     spi_en               launch strobe to spi_master
//     spi_mode             SPI mode to spi_master (reset value 1)
//     spi_sdata            transmit frame to spi_master
//     spi_rdata            received frame from spi_master
//     spi_done             1-cycle end-of-frame pulse from spi_master
//
//   Configuration macro:
//     RR_ARB_EN  defined   : round-robin arbitration starting at rr pointer
//                undefined : fixed priority, lowest index wins
//
//   FSM: IDLE -> SETUP -> LAUNCH -> WAIT -> DONE -> IDLE
//        (an illegal mode goes IDLE -> DONE with rsp_err)
// ---------------------------------------------------------------------------
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int MODE_SETUP_CYC = 50,
  parameter int EN_HOLD_CYC    = 100,
  parameter int TIMEOUT_CYC    = 2000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  spi_master_arbiter_if.slave req_if,
  output logic                spi_en,
  output logic [1:0]          spi_mode,
  output logic [15:0]         spi_sdata,
  input  logic [15:0]         spi_rdata,
  input  logic                spi_done
);

  localparam int CNT_MAX = (MODE_SETUP_CYC > EN_HOLD_CYC) ? MODE_SETUP_CYC : EN_HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(MODE_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(EN_HOLD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [TMO_W-1:0]     tmo_q,       tmo_d;
  logic [1:0]           last_mode_q, last_mode_d;
  logic                 spi_en_q,    spi_en_d;
  logic [1:0]           spi_mode_q,  spi_mode_d;
  logic [15:0]          spi_sdata_q, spi_sdata_d;
  logic [ID_W-1:0]      gnt_id_q,    gnt_id_d;
  logic                 busy_q,      busy_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [1:0]           win_mode;
  logic [15:0]          win_wdata;
  logic [NUM_REQ-1:0]   req_ready;

`ifdef RR_ARB_EN
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   rot_valid;
`endif

  // Arbitration: pick one winner among the active requests.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef RR_ARB_EN
    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // first set bit of the rotated vector is the round-robin winner.
    rot_valid = NUM_REQ'({req_if.req_valid, req_if.req_valid} >> rr_ptr_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && rot_valid[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_if.req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
`endif
  end

  // Winner's mode/data mux and one-hot decodes of winner and owner.
  always_comb begin
    win_mode   = 2'd0;
    win_wdata  = 16'd0;
    win_onehot = '0;
    gnt_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        win_mode  = req_if.req_mode[2*k +: 2];
        win_wdata = req_if.req_wdata[16*k +: 16];
      end
      win_onehot[k] = win_found && (win_idx == ID_W'(k));
      gnt_onehot[k] = (gnt_id_q == ID_W'(k));
    end
  end

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    last_mode_d = last_mode_q;
    spi_en_d    = spi_en_q;
    spi_mode_d  = spi_mode_q;
    spi_sdata_d = spi_sdata_q;
    gnt_id_d    = gnt_id_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
`ifdef RR_ARB_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          // Ready is combinational so the accept happens in the same cycle
          // the request is seen; data and mode are captured at this edge.
          req_ready   = win_onehot;
          gnt_id_d    = win_idx;
          spi_sdata_d = win_wdata;
          cnt_d       = '0;
`ifdef RR_ARB_EN
          rr_ptr_d    = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`endif
          if (win_mode[0]) begin
            spi_mode_d = win_mode;
            state_d    = S_SETUP;
          end else begin
            // Modes 0/2 are never presented to the master: keep the current
            // spi_mode and finish the grant with an error.
            rsp_valid_d = win_onehot;
            rsp_rdata_d = 16'd0;
            rsp_err_d   = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_SETUP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A mode change needs time for the master to park spi_clk at the
        // new idle polarity before spi_en rises.
        if ((spi_mode_q == last_mode_q) || (cnt_q == SETUP_LAST)) begin
          spi_en_d = 1'b1;
          cnt_d    = '0;
          tmo_d    = '0;
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        tmo_d = tmo_q + TMO_W'(1);
        if (spi_done) begin
          spi_en_d    = 1'b0;
          rsp_valid_d = gnt_onehot;
          rsp_rdata_d = spi_rdata;
          rsp_err_d   = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q == HOLD_LAST) begin
          // spi_en must drop before the master reaches STOP so it does not
          // start a second frame in the same grant.
          spi_en_d = 1'b0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (spi_done) begin
          rsp_valid_d = gnt_onehot;
          rsp_rdata_d = spi_rdata;
          rsp_err_d   = 1'b0;
          state_d     = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = gnt_onehot;
          rsp_rdata_d = 16'd0;
          rsp_err_d   = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        last_mode_d = spi_mode_q;
        state_d     = S_IDLE;
      end

      default: begin
        spi_en_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      last_mode_q <= 2'd1;
      spi_en_q    <= 1'b0;
      spi_mode_q  <= 2'd1;
      spi_sdata_q <= 16'd0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= 16'd0;
      rsp_err_q   <= 1'b0;
`ifdef RR_ARB_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      last_mode_q <= last_mode_d;
      spi_en_q    <= spi_en_d;
      spi_mode_q  <= spi_mode_d;
      spi_sdata_q <= spi_sdata_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef RR_ARB_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign req_if.req_ready = req_ready;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
  assign req_if.rsp_err   = rsp_err_q;
  assign req_if.busy      = busy_q;
  assign req_if.gnt_id    = gnt_id_q;

  assign spi_en    = spi_en_q;
  assign spi_mode  = spi_mode_q;
  assign spi_sdata = spi_sdata_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MSC     = 8;
  localparam int EHC     = 10;
  localparam int TMO     = 60;
  localparam int MDL_DLY = 14;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        spi_en;
  logic [1:0]  spi_mode;
  logic [15:0] spi_sdata;
  logic [15:0] spi_rdata = 16'd0;
  logic        spi_done = 1'b0;

  spi_master_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) ifc ();

  spi_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MODE_SETUP_CYC(MSC),
    .EN_HOLD_CYC(EHC), .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_if(ifc),
    .spi_en(spi_en), .spi_mode(spi_mode), .spi_sdata(spi_sdata),
    .spi_rdata(spi_rdata), .spi_done(spi_done)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    int          id;
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t rsp_q[$];
  int   gnt_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  int n_ready = 0, n_launch = 0;
  int ready_cyc = 0, launch_cyc = 0, rsp_cyc = 0;
  int en_run = 0, last_en_run = 0, low3_run = 0, launch_low3 = 0;
  bit en_prev = 1'b0;
  int mon_id;
  rsp_t mon_rsp;

  bit mdl_off = 1'b0, mdl_active = 1'b0;
  int mdl_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge sys_clk) cyc++;

  // Behavioural spi_master: loopback miso=mosi, spi_done MDL_DLY cycles after spi_en rises.
  always @(posedge sys_clk) begin
    #1;
    spi_done = 1'b0;
    if (!sys_rst_n) mdl_active = 1'b0;
    else if (mdl_active) begin
      mdl_cnt++;
      if (mdl_cnt == MDL_DLY) begin
        spi_rdata  = spi_sdata;
        spi_done   = 1'b1;
        mdl_active = 1'b0;
      end
    end else if (spi_en && !mdl_off) begin
      mdl_active = 1'b1;
      mdl_cnt    = 0;
    end
  end

  // Monitor: grants and responses against the scoreboard, spi_en timing.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (ifc.req_ready != '0) begin
        n_ready++;
        ready_cyc = cyc;
        if (gnt_q.size() == 0) check("unexpected_ready", 32'(ifc.req_ready), 0);
        else begin
          mon_id = gnt_q.pop_front();
          check("grant", 32'(ifc.req_ready), 32'(1) << mon_id);
        end
      end
      if (ifc.rsp_valid != '0) begin
        rsp_cyc = cyc;
        if (rsp_q.size() == 0) check("unexpected_rsp", 32'(ifc.rsp_valid), 0);
        else begin
          mon_rsp = rsp_q.pop_front();
          check("rsp_valid", 32'(ifc.rsp_valid), 32'(1) << mon_rsp.id);
          check("rsp_rdata", 32'(ifc.rsp_rdata), 32'(mon_rsp.rdata));
          check("rsp_err", 32'(ifc.rsp_err), 32'(mon_rsp.err));
        end
      end
      if (spi_en) begin
        if (!en_prev) begin
          launch_cyc  = cyc;
          launch_low3 = low3_run;
          n_launch++;
        end
        en_run++;
      end else begin
        if (en_prev) last_en_run = en_run;
        en_run   = 0;
        low3_run = (spi_mode == 2'd3) ? low3_run + 1 : 0;
      end
      en_prev = spi_en;
    end else begin
      en_prev  = 1'b0;
      en_run   = 0;
      low3_run = 0;
    end
  end

  task automatic push_exp(input int id, input logic [15:0] wd, input bit err);
    rsp_t r;
    r.id    = id;
    r.rdata = err ? 16'd0 : wd;
    r.err   = err;
    gnt_q.push_back(id);
    rsp_q.push_back(r);
  endtask

  task automatic send(input int id, input logic [1:0] mode, input logic [15:0] wd, input bit err);
    bit ok;
    push_exp(id, wd, err);
    @(posedge sys_clk); #1;
    ifc.req_mode[2*id +: 2]   = mode;
    ifc.req_wdata[16*id +: 16] = wd;
    ifc.req_valid[id]          = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge sys_clk);
      if (ifc.req_ready[id]) ok = 1'b1;
    end
    @(posedge sys_clk); #1;
    ifc.req_valid[id] = 1'b0;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    check("drain", 32'(rsp_q.size()), 0);
  endtask

  initial begin
    int launches_before, n_target, wait_n;
    ifc.req_valid = '0;
    ifc.req_mode  = '0;
    ifc.req_wdata = '0;

    // 1: reset values
    repeat (3) @(negedge sys_clk);
    check("rst_ready", 32'(ifc.req_ready), 0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(ifc.rsp_rdata), 0);
    check("rst_rsp_err", 32'(ifc.rsp_err), 0);
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_gnt_id", 32'(ifc.gnt_id), 0);
    check("rst_spi_en", 32'(spi_en), 0);
    check("rst_spi_mode", 32'(spi_mode), 1);
    check("rst_spi_sdata", 32'(spi_sdata), 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("idle_busy", 32'(ifc.busy), 0);
    check("idle_spi_en", 32'(spi_en), 0);

    // 2: single frame, same mode -> one SETUP cycle, EN_HOLD pulse, loopback data
    send(0, 2'd1, 16'hA5C3, 1'b0);
    drain();
    check("same_mode_latency", 32'(launch_cyc - ready_cyc), 2);
    check("en_hold_len", 32'(last_en_run), EHC);

    // 3: mode change 1 -> 3 holds spi_en low with the new mode before launch
    send(0, 2'd1, 16'h1234, 1'b0);
    drain();
    send(1, 2'd3, 16'hBEEF, 1'b0);
    drain();
    check("mode_setup_low", 32'(launch_low3 >= MSC), 1);
    check("mode_chg_latency", 32'(launch_cyc - ready_cyc), MSC + 1);
    check("mode3_out", 32'(spi_mode), 3);

    // 6: illegal mode -> accepted, error response, no launch
    launches_before = n_launch;
    send(2, 2'd2, 16'h0F0F, 1'b1);
    drain();
    check("illegal_no_launch", 32'(n_launch), 32'(launches_before));

    // 5: master silent -> timeout TMO cycles after launch; a withdrawn request is ignored
    mdl_off = 1'b1;
    send(3, 2'd1, 16'h5555, 1'b1);
    @(posedge sys_clk); #1;
    ifc.req_valid[1] = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    ifc.req_valid[1] = 1'b0;
    drain();
    mdl_off = 1'b0;
    check("timeout_latency", 32'(rsp_cyc - launch_cyc), TMO);
    check("timeout_en_len", 32'(last_en_run), EHC);

    // 4: all requesters held high for 8 grants
    n_target = n_ready + 8;
    for (int g = 0; g < 8; g++) begin
`ifdef RR_ARB_EN
      push_exp(g % NUM_REQ, 16'hC000 + 16'(g % NUM_REQ), 1'b0);
`else
      push_exp(0, 16'hC000, 1'b0);
`endif
    end
    @(posedge sys_clk); #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      ifc.req_mode[2*k +: 2]   = 2'd1;
      ifc.req_wdata[16*k +: 16] = 16'hC000 + 16'(k);
    end
    ifc.req_valid = '1;
    wait_n = 0;
    while (n_ready < n_target && wait_n < 3000) begin
      @(negedge sys_clk);
      wait_n++;
    end
    @(posedge sys_clk); #1;
    ifc.req_valid = '0;
    check("burst_grants", 32'(n_ready), 32'(n_target));
    drain();
    check("gnt_q_empty", 32'(gnt_q.size()), 0);

    // Asynchronous reset mid-frame returns to IDLE at once
    send(1, 2'd1, 16'h7777, 1'b0);
    wait_n = 0;
    while (!spi_en && wait_n < 100) begin
      @(negedge sys_clk);
      wait_n++;
    end
    check("pre_rst_spi_en", 32'(spi_en), 1);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_spi_en", 32'(spi_en), 0);
    check("async_rst_busy", 32'(ifc.busy), 0);
    rsp_q.delete();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("post_rst_busy", 32'(ifc.busy), 0);
    check("post_rst_mode", 32'(spi_mode), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
